mem_stage_dmem: RTL and testbench
=================================

Name: mem_stage_dmem

Overview:
- Memory stage of the RV32I pipeline. Consumes the EX/M register outputs.
- Performs data-memory loads and stores (byte/half/word, signed/unsigned) on an internal word-organised RAM.
- Registers results into the M/WB pipeline register that feeds write-back.
- Flags misaligned accesses and invalid access modes.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the data RAM (default 1024 words = 4 KiB).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- regWrite_M  in  1  register-file write enable from EX/M
- memWrite_M  in  1  store request
- memRead_M  in  1  load request
- resultScr_M  in  3  write-back source select, passed through
- alu_rsl_M  in  32  byte address for loads/stores; also the ALU result passed to WB
- write_Data_M  in  32  store data; source lanes are [7:0], [15:0] or [31:0]
- rd_M  in  5  destination register
- mode_M  in  3  access mode, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- pcPlus4_M  in  32  PC+4, passed through
- regWrite_W  out  1  registered regWrite
- resultScr_W  out  3  registered resultScr_M
- alu_rsl_W  out  32  registered alu_rsl_M
- read_Data_W  out  32  registered, extended load data
- rd_W  out  5  registered rd_M
- pcPlus4_W  out  32  registered pcPlus4_M
- mem_err_W  out  1  registered error: misaligned access or invalid mode on a load/store

Behaviour:
- Reset (rst_n=0 at posedge): all outputs go to 0. RAM contents are not cleared.
- Reset mid-operation: a store presented in a reset cycle is NOT written.
- Addressing:
  - word index = alu_rsl_M[DEPTH_LOG2+1:2]; byte offset = alu_rsl_M[1:0].
  - Upper address bits are ignored, so addresses alias/wrap modulo 4*2^DEPTH_LOG2.
- Error detection (combinational): err = (memRead_M | memWrite_M) & (misaligned | invalid).
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00. B/BU are never misaligned.
  - invalid: mode in {011, 110, 111}.
- Store path:
  - Write occurs at posedge when memWrite_M=1 and err=0.
  - Byte-lane enables:
    - B: lane = offset; data[7:0] replicated to that lane.
    - H: lanes {1,0} if offset=00, {3,2} if offset=10; data[15:0].
    - W: all lanes; data[31:0].
  - Unwritten lanes are preserved.
  - A store with err=1 writes nothing.
  - Modes BU/HU on a store are invalid (err=1).
- Load path:
  - RAM is read asynchronously at the word index; the result is registered into read_Data_W on the same edge.
  - Load-to-WB latency: 1 cycle.
  - Extraction:
    - B: sign-extend byte at offset.
    - BU: zero-extend byte at offset.
    - H: sign-extend half at offset[1].
    - HU: zero-extend half at offset[1].
    - W: full word.
  - read_Data_W = 0 when memRead_M=0 or err=1.
- Write/read ordering:
  - Store at cycle N followed by a load of the same address at cycle N+1 returns the new data.
  - memRead_M and memWrite_M both 1 in one cycle: the store is performed; read_Data_W returns the OLD (pre-write) word contents, extended per mode.
- Pass-through: regWrite, resultScr, alu_rsl, rd and pcPlus4 are registered unchanged every non-reset cycle. There is no stall or flush input.
- mem_err_W:
  - Registered err; held for exactly one cycle per offending instruction.
  - Does NOT suppress regWrite_W; hazard/exception logic downstream decides.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with nonzero inputs -> all outputs 0. Release -> outputs equal the previous-cycle inputs after 1 clk.
- Word store/load: SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> read_Data_W=0xDEADBEEF one cycle after the LW, mem_err_W=0.
- Byte lanes and sign extension on word 0x11223344 @0x20:
  - SB 0xA5 @0x21, then LW -> 0x1122A544.
  - LB @0x21 -> 0xFFFFFFA5.
  - LBU @0x21 -> 0x000000A5.
  - LH @0x22 -> 0x00001122.
- Halfword: SH 0x8001 @0x32 on a zeroed word -> LW=0x80010000, LH @0x32 -> 0xFFFF8001, LHU -> 0x00008001.
- Errors:
  - SW @0x41 -> no write (LW @0x40 unchanged), mem_err_W=1 for one cycle.
  - LH @0x43 -> read_Data_W=0, mem_err_W=1.
  - mode 011 load -> mem_err_W=1.
  - memRead=memWrite=0 with a misaligned address -> mem_err_W=0.
- Aliasing/reset: with DEPTH_LOG2=10, SW 0x5 @0x1004, then LW @0x0004 -> 0x5. Assert rst_n=0 during an SW -> no write, and data written earlier is retained after reset.

Source files
------------

// File: rtl/mem_stage_dmem_if.sv
// EX/M -> M/WB bus of the memory stage: pipeline-register inputs from EX/M and
// the registered M/WB outputs. The stage itself uses the slave modport.
interface mem_stage_dmem_if;
    // EX/M side
    logic        regWrite_M;
    logic        memWrite_M;
    logic        memRead_M;
    logic [2:0]  resultScr_M;
    logic [31:0] alu_rsl_M;
    logic [31:0] write_Data_M;
    logic [4:0]  rd_M;
    logic [2:0]  mode_M;
    logic [31:0] pcPlus4_M;

    // M/WB side
    logic        regWrite_W;
    logic [2:0]  resultScr_W;
    logic [31:0] alu_rsl_W;
    logic [31:0] read_Data_W;
    logic [4:0]  rd_W;
    logic [31:0] pcPlus4_W;
    logic        mem_err_W;

    modport master (
        output regWrite_M, memWrite_M, memRead_M, resultScr_M, alu_rsl_M,
               write_Data_M, rd_M, mode_M, pcPlus4_M,
        input  regWrite_W, resultScr_W, alu_rsl_W, read_Data_W, rd_W,
               pcPlus4_W, mem_err_W
    );

    modport slave (
        input  regWrite_M, memWrite_M, memRead_M, resultScr_M, alu_rsl_M,
               write_Data_M, rd_M, mode_M, pcPlus4_M,
        output regWrite_W, resultScr_W, alu_rsl_W, read_Data_W, rd_W,
               pcPlus4_W, mem_err_W
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// RV32I memory stage: word-organised data RAM with byte/half/word loads and
// stores, misalignment/invalid-mode detection, and the M/WB pipeline register.
module mem_stage_dmem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_stage_dmem_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } mode_e;

    typedef struct packed {
        logic        reg_write;
        logic [2:0]  result_scr;
        logic [31:0] alu_rsl;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic        mem_err;
    } wb_t;

    // Address split; bits above the RAM size are ignored so addresses wrap.
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            byte_off;

    assign word_idx = bus.alu_rsl_M[DEPTH_LOG2+1:2];
    assign byte_off = bus.alu_rsl_M[1:0];

    // ---------------------------------------------------------------------
    // Mode decode and error detection
    // ---------------------------------------------------------------------
    logic is_byte;
    logic is_half;
    logic is_word;
    logic sign_ext;
    logic load_only;
    logic mode_bad;
    logic misaligned;
    logic invalid;
    logic access;
    logic err;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        sign_ext  = 1'b0;
        load_only = 1'b0;
        mode_bad  = 1'b0;
        case (bus.mode_M)
            MODE_B:  begin is_byte = 1'b1; sign_ext  = 1'b1; end
            MODE_BU: begin is_byte = 1'b1; load_only = 1'b1; end
            MODE_H:  begin is_half = 1'b1; sign_ext  = 1'b1; end
            MODE_HU: begin is_half = 1'b1; load_only = 1'b1; end
            MODE_W:  is_word  = 1'b1;
            default: mode_bad = 1'b1;
        endcase
    end

    // Unsigned variants have no meaning for a store, so they count as invalid there.
    assign invalid    = mode_bad | (bus.memWrite_M & load_only);
    assign misaligned = (is_half & byte_off[0]) | (is_word & (byte_off != 2'b00));
    assign access     = bus.memRead_M | bus.memWrite_M;
    assign err        = access & (misaligned | invalid);

    // ---------------------------------------------------------------------
    // Store path: lane enables and lane-replicated write data
    // ---------------------------------------------------------------------
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic        do_store;

    always_comb begin
        byte_en = 4'b0000;
        wr_data = 32'h0;
        if (is_byte) begin
            byte_en = 4'b0001 << byte_off;
            wr_data = {4{bus.write_Data_M[7:0]}};
        end else if (is_half) begin
            byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.write_Data_M[15:0]}};
        end else if (is_word) begin
            byte_en = 4'b1111;
            wr_data = bus.write_Data_M;
        end
    end

    // A store presented while reset is asserted must not reach the RAM.
    assign do_store = rst_n & bus.memWrite_M & ~err;

    // NOTE: the RAM array is deliberately not reset; clearing it would need a
    // write to every word, and software never relies on its initial contents.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load path: asynchronous read, lane extraction and extension
    // ---------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    // Read happens before the write lands on this edge, so a combined
    // load+store returns the pre-write word.
    assign rd_word = mem_q[word_idx];

    always_comb begin
        case (byte_off)
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        if (bus.memRead_M && !err) begin
            if (is_byte)      load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            else if (is_half) load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
            else if (is_word) load_data = rd_word;
        end
    end

    // ---------------------------------------------------------------------
    // M/WB pipeline register
    // ---------------------------------------------------------------------
    wb_t wb_d;
    wb_t wb_q;

    // The error flag does not gate regWrite; downstream hazard logic decides.
    always_comb begin
        wb_d.reg_write  = bus.regWrite_M;
        wb_d.result_scr = bus.resultScr_M;
        wb_d.alu_rsl    = bus.alu_rsl_M;
        wb_d.read_data  = load_data;
        wb_d.rd         = bus.rd_M;
        wb_d.pc_plus4   = bus.pcPlus4_M;
        wb_d.mem_err    = err;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) wb_q <= '0;
        else        wb_q <= wb_d;
    end

    assign bus.regWrite_W  = wb_q.reg_write;
    assign bus.resultScr_W = wb_q.result_scr;
    assign bus.alu_rsl_W   = wb_q.alu_rsl;
    assign bus.read_Data_W = wb_q.read_data;
    assign bus.rd_W        = wb_q.rd;
    assign bus.pcPlus4_W   = wb_q.pc_plus4;
    assign bus.mem_err_W   = wb_q.mem_err;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem: directed scenarios plus randomized
// traffic against a byte-addressed reference memory model.
module tb_mem_stage_dmem;
    localparam int DL2       = 10;
    localparam int MEM_BYTES = 4 << DL2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_stage_dmem_if bus();

    mem_stage_dmem #(.DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain byte array plus expected M/WB values of the last step.
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        exp_rw;
    logic [2:0]  exp_scr;
    logic [31:0] exp_alu;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_rd;
    logic [31:0] exp_pc;
    logic        exp_err;

    task automatic model_op(input logic mr, input logic mw, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic rst_ok, output logic err, output logic [31:0] rdata);
        int          size;
        bit          sgn;
        bit          inval;
        bit          mis;
        int unsigned base;
        logic [31:0] val;
        size = 1; sgn = 0; inval = 0;
        case (mode)
            3'd0: begin size = 1; sgn = 1; end
            3'd4: begin size = 1; sgn = 0; end
            3'd1: begin size = 2; sgn = 1; end
            3'd5: begin size = 2; sgn = 0; end
            3'd2: begin size = 4; sgn = 0; end
            default: inval = 1;
        endcase
        if (mw && (mode == 3'd4 || mode == 3'd5)) inval = 1;
        base  = addr % MEM_BYTES;
        mis   = !inval && ((base % size) != 0);
        err   = (mr || mw) && (inval || mis);
        rdata = 32'h0;
        if (mr && !err) begin
            val = 32'h0;
            for (int k = 0; k < size; k++) val = val | (32'(ref_mem[base + k]) << (8 * k));
            if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
            rdata = val;
        end
        if (mw && !err && rst_ok) begin
            for (int k = 0; k < size; k++) ref_mem[base + k] = data[8*k +: 8];
        end
    endtask

    // Drive one EX/M cycle, predict the M/WB outputs, and sample after the edge.
    task automatic step(input logic rst, input logic rw, input logic mw, input logic mr,
                        input logic [2:0] scr, input logic [2:0] mode, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc);
        logic        e_err;
        logic [31:0] e_rdata;
        rst_n            = rst;
        bus.regWrite_M   = rw;
        bus.memWrite_M   = mw;
        bus.memRead_M    = mr;
        bus.resultScr_M  = scr;
        bus.alu_rsl_M    = alu;
        bus.write_Data_M = wd;
        bus.rd_M         = rd;
        bus.mode_M       = mode;
        bus.pcPlus4_M    = pc;
        model_op(mr, mw, mode, alu, wd, rst, e_err, e_rdata);
        if (!rst) begin
            {exp_rw, exp_scr, exp_alu, exp_rdata, exp_rd, exp_pc, exp_err} = '0;
        end else begin
            exp_rw = rw; exp_scr = scr; exp_alu = alu; exp_rdata = e_rdata;
            exp_rd = rd; exp_pc = pc; exp_err = e_err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic mr, input logic mw, input logic [2:0] mode,
                      input logic [31:0] addr, input logic [31:0] data);
        step(1'b1, 1'b1, mw, mr, 3'($urandom), mode, 5'($urandom), addr, data, $urandom);
    endtask

    task automatic test_reset;
        logic [109:0] all_out;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 3'b101, 3'b010, 5'd17, 32'h0000_0300, 32'h1234_5678, 32'h0000_1004);
            all_out = {bus.regWrite_W, bus.resultScr_W, bus.alu_rsl_W, bus.read_Data_W,
                       bus.rd_W, bus.pcPlus4_W, bus.mem_err_W};
            n_checks++;
            if (all_out !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", i, all_out);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 3'b010, 5'd9, 32'h0000_0304, 32'h0, 32'h0000_2008);
        n_checks++;
        if ({bus.regWrite_W, bus.resultScr_W, bus.alu_rsl_W, bus.rd_W, bus.pcPlus4_W} !==
            {1'b1, 3'b011, 32'h0000_0304, 5'd9, 32'h0000_2008}) begin
            n_errors++;
            $display("FAIL release_passthru: got rw=%b scr=%h alu=%h rd=%0d pc=%h expected 1 3 00000304 9 00002008",
                     bus.regWrite_W, bus.resultScr_W, bus.alu_rsl_W, bus.rd_W, bus.pcPlus4_W);
        end
        n_checks++;
        if (bus.read_Data_W !== 32'h0 || bus.mem_err_W !== 1'b0) begin
            n_errors++;
            $display("FAIL release_idle: got rdata=%h err=%b expected 0 0", bus.read_Data_W, bus.mem_err_W);
        end
    endtask

    task automatic test_word;
        op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'hDEAD_BEEF || bus.mem_err_W !== 1'b0) begin
            n_errors++;
            $display("FAIL lw_word: got %h err=%b expected deadbeef err=0", bus.read_Data_W, bus.mem_err_W);
        end
    endtask

    task automatic test_byte_lanes;
        op(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344);
        op(1'b0, 1'b1, 3'b000, 32'h21, 32'h1234_56A5);
        op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h1122_A544) begin
            n_errors++; $display("FAIL sb_lane: got %h expected 1122a544", bus.read_Data_W);
        end
        op(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'hFFFF_FFA5) begin
            n_errors++; $display("FAIL lb_sext: got %h expected ffffffa5", bus.read_Data_W);
        end
        op(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h0000_00A5) begin
            n_errors++; $display("FAIL lbu_zext: got %h expected 000000a5", bus.read_Data_W);
        end
        op(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h0000_1122) begin
            n_errors++; $display("FAIL lh_upper: got %h expected 00001122", bus.read_Data_W);
        end
    endtask

    task automatic test_halfword;
        op(1'b0, 1'b1, 3'b010, 32'h30, 32'h0);
        op(1'b0, 1'b1, 3'b001, 32'h32, 32'h7F3C_8001);
        op(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h8001_0000) begin
            n_errors++; $display("FAIL sh_lane: got %h expected 80010000", bus.read_Data_W);
        end
        op(1'b1, 1'b0, 3'b001, 32'h32, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'hFFFF_8001) begin
            n_errors++; $display("FAIL lh_sext: got %h expected ffff8001", bus.read_Data_W);
        end
        op(1'b1, 1'b0, 3'b101, 32'h32, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h0000_8001) begin
            n_errors++; $display("FAIL lhu_zext: got %h expected 00008001", bus.read_Data_W);
        end
    endtask

    task automatic test_errors;
        op(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 3'b010, 5'd3, 32'h41, 32'h1234_5678, 32'h44);
        n_checks++;
        if (bus.mem_err_W !== 1'b1 || bus.regWrite_W !== 1'b1) begin
            n_errors++;
            $display("FAIL sw_misaligned: got err=%b rw=%b expected err=1 rw=1", bus.mem_err_W, bus.regWrite_W);
        end
        op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'hCAFE_F00D || bus.mem_err_W !== 1'b0) begin
            n_errors++;
            $display("FAIL sw_err_nowrite: got %h err=%b expected cafef00d err=0", bus.read_Data_W, bus.mem_err_W);
        end
        op(1'b1, 1'b0, 3'b001, 32'h43, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h0 || bus.mem_err_W !== 1'b1) begin
            n_errors++;
            $display("FAIL lh_misaligned: got %h err=%b expected 0 err=1", bus.read_Data_W, bus.mem_err_W);
        end
        op(1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h0 || bus.mem_err_W !== 1'b1) begin
            n_errors++;
            $display("FAIL mode_invalid: got %h err=%b expected 0 err=1", bus.read_Data_W, bus.mem_err_W);
        end
        op(1'b0, 1'b0, 3'b010, 32'h43, 32'h0);
        n_checks++;
        if (bus.mem_err_W !== 1'b0) begin
            n_errors++; $display("FAIL idle_misaligned: got err=%b expected 0", bus.mem_err_W);
        end
        op(1'b0, 1'b1, 3'b100, 32'h40, 32'h0000_0077);
        n_checks++;
        if (bus.mem_err_W !== 1'b1) begin
            n_errors++; $display("FAIL store_bu: got err=%b expected 1", bus.mem_err_W);
        end
        op(1'b1, 1'b1, 3'b010, 32'h40, 32'h1111_1111);
        n_checks++;
        if (bus.read_Data_W !== 32'hCAFE_F00D) begin
            n_errors++; $display("FAIL rw_same_cycle_old: got %h expected cafef00d", bus.read_Data_W);
        end
        op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h1111_1111) begin
            n_errors++; $display("FAIL rw_same_cycle_new: got %h expected 11111111", bus.read_Data_W);
        end
    endtask

    task automatic test_alias_reset;
        op(1'b0, 1'b1, 3'b010, 32'h1004, 32'h5);
        op(1'b1, 1'b0, 3'b010, 32'h0004, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h5) begin
            n_errors++; $display("FAIL alias_wrap: got %h expected 00000005", bus.read_Data_W);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 5'd1, 32'h4, 32'h99, 32'h8);
        n_checks++;
        if (bus.mem_err_W !== 1'b0 || bus.regWrite_W !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_store_out: got err=%b rw=%b expected 0 0", bus.mem_err_W, bus.regWrite_W);
        end
        op(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        n_checks++;
        if (bus.read_Data_W !== 32'h5) begin
            n_errors++; $display("FAIL reset_store_blocked: got %h expected 00000005", bus.read_Data_W);
        end
    endtask

    // Random traffic confined (modulo the RAM size) to a pre-filled window.
    task automatic test_random;
        logic [31:0] addr;
        for (int w = 0; w < 64; w++) op(1'b0, 1'b1, 3'b010, 32'h100 + 32'(4 * w), $urandom);
        for (int i = 0; i < 400; i++) begin
            addr = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 255)));
            step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), addr, $urandom, $urandom);
            n_checks++;
            if (bus.read_Data_W !== exp_rdata) begin
                n_errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, bus.read_Data_W, exp_rdata);
            end
            n_checks++;
            if (bus.mem_err_W !== exp_err) begin
                n_errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, bus.mem_err_W, exp_err);
            end
            n_checks++;
            if ({bus.regWrite_W, bus.resultScr_W, bus.alu_rsl_W, bus.rd_W, bus.pcPlus4_W} !==
                {exp_rw, exp_scr, exp_alu, exp_rd, exp_pc}) begin
                n_errors++;
                $display("FAIL rand_passthru[%0d]: got %h expected %h", i,
                         {bus.regWrite_W, bus.resultScr_W, bus.alu_rsl_W, bus.rd_W, bus.pcPlus4_W},
                         {exp_rw, exp_scr, exp_alu, exp_rd, exp_pc});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {bus.regWrite_M, bus.memWrite_M, bus.memRead_M, bus.resultScr_M, bus.alu_rsl_M,
         bus.write_Data_M, bus.rd_M, bus.mode_M, bus.pcPlus4_M} = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_word();
        test_byte_lanes();
        test_halfword();
        test_errors();
        test_alias_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
